iob_ram_be_arb: RTL and testbench

- Two-requester round-robin arbiter that shares one single-port, byte-enable, synchronous-read RAM (DATA_W/8 write strobes, registered read data, 1-cycle read latency).
- Each requester uses the native valid/ready request interface with rvalid/rdata read response.
- Sits between two masters (e.g. CPU data port and a DMA) and the RAM primitive, so a single RAM instance serves both masters without port duplication.

---
 rtl/iob_ram_be_arb.sv | 99 +++++++++
 tb/tb_iob_ram_be_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_be_arb.sv
// Two-requester round-robin front end for one single-port, byte-enable,
// synchronous-read RAM. Each requester sees a valid/ready request port
// and gets its own rvalid one cycle after a read is accepted. Read data
// for both requesters is the RAM output itself; rvalid says whose it is.
module iob_ram_be_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  r0_valid_i,
    input  logic [ADDR_W-1:0]     r0_addr_i,
    input  logic [DATA_W-1:0]     r0_wdata_i,
    input  logic [DATA_W/8-1:0]   r0_wstrb_i,
    output logic                  r0_ready_o,
    output logic                  r0_rvalid_o,
    output logic [DATA_W-1:0]     r0_rdata_o,

    input  logic                  r1_valid_i,
    input  logic [ADDR_W-1:0]     r1_addr_i,
    input  logic [DATA_W-1:0]     r1_wdata_i,
    input  logic [DATA_W/8-1:0]   r1_wstrb_i,
    output logic                  r1_ready_o,
    output logic                  r1_rvalid_o,
    output logic [DATA_W-1:0]     r1_rdata_o,

    output logic                  ram_en_o,
    output logic [DATA_W/8-1:0]   ram_wstrb_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_d_o,
    input  logic [DATA_W-1:0]     ram_d_i
);

    localparam int STRB_W = DATA_W / 8;

    // lastGrant: 0 = requester 0 served most recently, 1 = requester 1
    logic lastGrant;
    logic rdPend;
    logic rdOwner;
    logic grant0;
    logic grant1;
    logic rdAccept;

    // Round-robin pick: a lone requester always wins, contention goes to the one not served last
    always_comb begin
        grant0 = r0_valid_i && (!r1_valid_i || lastGrant);
        grant1 = r1_valid_i && (!r0_valid_i || !lastGrant);
    end

    // Steer the winner onto the RAM port; an idle cycle leaves the RAM disabled with no strobes
    always_comb begin
        ram_en_o    = 1'b0;
        ram_wstrb_o = '0;
        ram_addr_o  = '0;
        ram_d_o     = '0;
        rdAccept    = 1'b0;
        if (grant0) begin
            ram_en_o    = 1'b1;
            ram_wstrb_o = r0_wstrb_i;
            ram_addr_o  = r0_addr_i;
            ram_d_o     = r0_wdata_i;
            rdAccept    = (r0_wstrb_i == {STRB_W{1'b0}});
        end else if (grant1) begin
            ram_en_o    = 1'b1;
            ram_wstrb_o = r1_wstrb_i;
            ram_addr_o  = r1_addr_i;
            ram_d_o     = r1_wdata_i;
            rdAccept    = (r1_wstrb_i == {STRB_W{1'b0}});
        end
    end

    assign r0_ready_o = grant0;
    assign r1_ready_o = grant1;

    // Arbitration history plus a one-deep tracker for the read returning next cycle.
    // A read accepted while reset is high is dropped: rdPend is forced low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lastGrant <= 1'b1;
            rdPend    <= 1'b0;
            rdOwner   <= 1'b0;
        end else begin
            if (grant0) begin
                lastGrant <= 1'b0;
            end else if (grant1) begin
                lastGrant <= 1'b1;
            end
            rdPend  <= rdAccept;
            rdOwner <= grant1;
        end
    end

    assign r0_rvalid_o = rdPend && !rdOwner;
    assign r1_rvalid_o = rdPend && rdOwner;
    assign r0_rdata_o  = ram_d_i;
    assign r1_rdata_o  = ram_d_i;

endmodule

// File: tb/tb_iob_ram_be_arb.sv
// Bench for iob_ram_be_arb: a behavioural RAM sits on the RAM port, and a
// reference model (memory array, last-served flag, expected read return)
// predicts every cycle's grant, RAM drive and read response.
module tb_iob_ram_be_arb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    logic r0_valid, r1_valid;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic [STRB_W-1:0] r0_wstrb, r1_wstrb;
    logic r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic ram_en;
    logic [STRB_W-1:0] ram_wstrb;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d, ram_q;

    iob_ram_be_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_valid_i(r0_valid), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata), .r0_wstrb_i(r0_wstrb),
        .r0_ready_o(r0_ready), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
        .r1_valid_i(r1_valid), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata), .r1_wstrb_i(r1_wstrb),
        .r1_ready_o(r1_ready), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
        .ram_en_o(ram_en), .ram_wstrb_o(ram_wstrb), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
        .ram_d_i(ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: byte-enabled write, registered read on enabled reads
    logic [DATA_W-1:0] ramMem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < STRB_W; b++)
                if (ram_wstrb[b]) ramMem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
            if (ram_wstrb == '0) ram_q <= ramMem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] refMem [DEPTH];
    logic refLast;
    logic refPend;
    logic refOwner;
    logic [DATA_W-1:0] refData;
    int refG;
    logic obsG1, lastRv0, lastRv1;
    logic [DATA_W-1:0] lastRd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model at the rising edge
    task automatic cyc(input logic r, input logic v0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0, input logic [STRB_W-1:0] s0,
                       input logic v1, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d1, input logic [STRB_W-1:0] s1);
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd;
        logic [STRB_W-1:0] gs;
        rst = r;
        r0_valid = v0; r0_addr = a0; r0_wdata = d0; r0_wstrb = s0;
        r1_valid = v1; r1_addr = a1; r1_wdata = d1; r1_wstrb = s1;
        if (v0 && v1) refG = refLast ? 0 : 1;
        else if (v0)  refG = 0;
        else if (v1)  refG = 1;
        else          refG = 2;
        ga = (refG == 1) ? a1 : a0;
        gd = (refG == 1) ? d1 : d0;
        gs = (refG == 1) ? s1 : s0;
        @(negedge clk);
        chk("r0_ready", r0_ready, refG == 0);
        chk("r1_ready", r1_ready, refG == 1);
        chk("ram_en", ram_en, refG != 2);
        if (refG != 2) begin
            chk("ram_addr", ram_addr, ga);
            chk("ram_d", ram_d, gd);
            chk("ram_wstrb", ram_wstrb, gs);
        end else begin
            chk("ram_wstrb_idle", ram_wstrb, 0);
        end
        chk("r0_rvalid", r0_rvalid, refPend && !refOwner);
        chk("r1_rvalid", r1_rvalid, refPend && refOwner);
        if (refPend) chk("rdata", refOwner ? r1_rdata : r0_rdata, refData);
        obsG1 = r1_ready; lastRv0 = r0_rvalid; lastRv1 = r1_rvalid; lastRd0 = r0_rdata;
        @(posedge clk);
        if (refG != 2)
            for (int b = 0; b < STRB_W; b++)
                if (gs[b]) refMem[ga][8*b +: 8] = gd[8*b +: 8];
        if (r) begin
            refLast = 1'b1;
            refPend = 1'b0;
        end else begin
            if (refG != 2) refLast = refG[0];
            if (refG != 2 && gs == '0) begin
                refPend = 1'b1; refOwner = refG[0]; refData = refMem[ga];
            end else begin
                refPend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic r);
        cyc(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic req0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        cyc(0, 1, a, d, s, 0, 0, 0, 0);
    endtask
    task automatic req1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        cyc(0, 0, 0, 0, 0, 1, a, d, s);
    endtask

    logic [7:0] altSeq;
    int i0, i1;
    logic h0, h1;
    logic v0, v1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic [STRB_W-1:0] s0, s1;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ramMem[i] = '0; refMem[i] = '0;
        end
        ram_q = '0;
        rst = 1'b1;
        r0_valid = 0; r0_addr = 0; r0_wdata = 0; r0_wstrb = 0;
        r1_valid = 0; r1_addr = 0; r1_wdata = 0; r1_wstrb = 0;
        repeat (2) @(posedge clk);
        #1;
        refLast = 1'b1; refPend = 1'b0; refOwner = 1'b0; refData = '0; refG = 2;
        idle(1);

        // r0 fills the RAM, then reads it back; r1 stays idle
        for (int i = 0; i < DEPTH; i++) req0(i[ADDR_W-1:0], 32 + i, 4'hF);
        for (int i = 0; i < DEPTH; i++) req0(i[ADDR_W-1:0], 0, 4'h0);
        idle(0);
        chk("last_read_rdata", lastRd0, 32 + DEPTH - 1);

        // Partial write from r1 merges into r0's word
        req0(3, 32'h11223344, 4'hF);
        req1(3, 32'hAABBCCDD, 4'b0101);
        req0(3, 0, 4'h0);
        idle(0);
        chk("byte_merge", lastRd0, 32'h11BB33DD);

        // Continuous contention after reset alternates starting with r0
        idle(1);
        i0 = 0; i1 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 1 + i0, 0, 0, 1, 9 + i1, 0, 0);
            altSeq[k] = obsG1;
            if (refG == 0) i0++; else if (refG == 1) i1++;
        end
        idle(0);
        chk("alt_seq", altSeq, 8'hAA);

        // r1 served alone, then contention goes to r0
        for (int k = 0; k < 3; k++) req1(k, 0, 0);
        cyc(0, 1, 6, 0, 0, 1, 7, 0, 0);
        chk("contend_after_r1", obsG1, 0);
        cyc(0, 0, 0, 0, 0, 1, 7, 0, 0);
        idle(0);

        // Storage is shared: r1 writes, r0 reads
        for (int i = 0; i < DEPTH; i++) req1(i[ADDR_W-1:0], 64 + i, 4'hF);
        for (int i = 0; i < DEPTH; i++) req0(i[ADDR_W-1:0], 0, 4'h0);
        idle(0);
        chk("shared_last", lastRd0, 64 + DEPTH - 1);

        // Read accepted under reset yields no rvalid; contention then favours r0
        req0(2, 0, 0);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("reset_drop_rv0", lastRv0, 0);
        cyc(0, 1, 8, 0, 0, 1, 9, 0, 0);
        chk("post_reset_first", obsG1, 0);
        cyc(0, 0, 0, 0, 0, 1, 9, 0, 0);
        idle(0);

        // Random traffic; a requester kept waiting holds its request
        h0 = 0; h1 = 0;
        v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!h0) begin
                v0 = ($urandom_range(0, 9) < 7);
                a0 = $urandom; d0 = $urandom;
                s0 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if (!h1) begin
                v1 = ($urandom_range(0, 9) < 7);
                a1 = $urandom; d1 = $urandom;
                s1 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            cyc(0, v0, a0, d0, s0, v1, a1, d1, s1);
            h0 = v0 && (refG != 0);
            h1 = v1 && (refG != 1);
        end
        idle(0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
